bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
//
// Shares the core's single Sysbus request/response port between the
// instruction cache (IC) and the data cache (DC). One cache owns the bus for
// a whole line transfer: an address beat, then either BEATS write-data beats
// (write) or BEATS tagged response beats (read). Ties in IDLE are broken
// round-robin against the previous grant. There is always at least one IDLE
// cycle between transactions.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   ic_reqcyc/ic_req/ic_reqtag    I-cache request (valid, address/data, tag)
//   ic_reqack                     bus accepted the current I-cache beat
//   ic_respcyc / ic_respack       response beat valid / consumed (I-cache)
//   dc_*                          same set for the D-cache
//   bus_reqcyc/bus_req/bus_reqtag request beat towards the Sysbus
//   bus_reqack                    Sysbus accepted the request beat
//   bus_respcyc/bus_resptag       response beat from the Sysbus
//   bus_respack                   response beat consumed
//   busy                          a transaction is in progress
//
// All outputs are combinational from state, owner and the current inputs.

module bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      ic_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] ic_req,
    input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag,
    output logic                      ic_reqack,
    output logic                      ic_respcyc,
    input  logic                      ic_respack,

    input  logic                      dc_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] dc_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag,
    output logic                      dc_reqack,
    output logic                      dc_respcyc,
    input  logic                      dc_respack,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,

    output logic                      busy
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // Direction lives in the tag MSB: 1 = read, 0 = write.
    localparam int DIR_BIT = BUS_TAG_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RESP
    } state_t;

    state_t                     state, state_nx;
    logic                       owner, owner_nx;           // 0 = IC, 1 = DC
    logic                       last_grant, last_grant_nx;
    logic [CNT_W-1:0]           cnt, cnt_nx;
    logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_nx;

    logic                       grant_dc;
    logic                       own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0]  own_req;
    logic [BUS_TAG_WIDTH-1:0]   own_reqtag;
    logic                       own_respack;
    logic                       own_reqack;
    logic                       own_respcyc;
    logic                       beat_vld;
    logic                       beat_take;
    logic                       wbeat_take;

    // On a tie, the client that did not win last time gets the bus.
    assign grant_dc = (ic_reqcyc && dc_reqcyc) ? ~last_grant : dc_reqcyc;

    assign own_reqcyc  = owner ? dc_reqcyc  : ic_reqcyc;
    assign own_req     = owner ? dc_req     : ic_req;
    assign own_reqtag  = owner ? dc_reqtag  : ic_reqtag;
    assign own_respack = owner ? dc_respack : ic_respack;

    // Response beats carrying someone else's tag are neither forwarded nor counted.
    assign beat_vld   = bus_respcyc && (bus_resptag == tag_q);
    assign beat_take  = beat_vld && own_respack;
    assign wbeat_take = bus_reqack && own_reqcyc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            cnt        <= '0;
            tag_q      <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_grant_nx;
            cnt        <= cnt_nx;
            tag_q      <= tag_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        tag_nx        = tag_q;
        bus_reqcyc    = 1'b0;
        bus_req       = '0;
        bus_reqtag    = '0;
        bus_respack   = 1'b0;
        own_reqack    = 1'b0;
        own_respcyc   = 1'b0;

        case (state)
            S_IDLE: begin
                if (ic_reqcyc || dc_reqcyc) begin
                    owner_nx      = grant_dc;
                    last_grant_nx = grant_dc;
                    tag_nx        = grant_dc ? dc_reqtag : ic_reqtag;
                    state_nx      = S_ADDR;
                end
            end

            S_ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = own_req;
                bus_reqtag = own_reqtag;
                own_reqack = bus_reqack;
                if (bus_reqack) begin
                    cnt_nx   = '0;
                    state_nx = tag_q[DIR_BIT] ? S_RESP : S_WDATA;
                end
            end

            S_WDATA: begin
                // A pause in the owner's reqcyc simply stalls the burst.
                bus_reqcyc = own_reqcyc;
                bus_req    = own_req;
                bus_reqtag = tag_q;
                own_reqack = wbeat_take;
                if (wbeat_take) begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_nx = S_IDLE;
                    end
                end
            end

            S_RESP: begin
                own_respcyc = beat_vld;
                bus_respack = beat_take;
                if (beat_take) begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_nx = S_IDLE;
                    end
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign ic_reqack  = own_reqack  && !owner;
    assign dc_reqack  = own_reqack  &&  owner;
    assign ic_respcyc = own_respcyc && !owner;
    assign dc_respcyc = own_respcyc &&  owner;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_reqcyc, dc_reqcyc;
    logic [DW-1:0] ic_req, dc_req;
    logic [TW-1:0] ic_reqtag, dc_reqtag;
    logic          ic_reqack, dc_reqack, ic_respcyc, dc_respcyc;
    logic          ic_respack, dc_respack;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack, bus_respcyc;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Compact view of the control outputs: {bus_reqcyc, ic_reqack, dc_reqack,
    // ic_respcyc, dc_respcyc, bus_respack, busy}
    logic [6:0]  ov;
    logic [95:0] all_out;
    assign ov = {bus_reqcyc, ic_reqack, dc_reqack, ic_respcyc, dc_respcyc, bus_respack, busy};
    assign all_out = {12'd0, bus_reqcyc, bus_req, bus_reqtag, ic_reqack, dc_reqack,
                      ic_respcyc, dc_respcyc, bus_respack, busy};

    bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .ic_reqcyc(ic_reqcyc), .ic_req(ic_req), .ic_reqtag(ic_reqtag),
        .ic_reqack(ic_reqack), .ic_respcyc(ic_respcyc), .ic_respack(ic_respack),
        .dc_reqcyc(dc_reqcyc), .dc_req(dc_req), .dc_reqtag(dc_reqtag),
        .dc_reqack(dc_reqack), .dc_respcyc(dc_respcyc), .dc_respack(dc_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ic_reqcyc = 0; dc_reqcyc = 0;
        ic_req = '0; dc_req = '0; ic_reqtag = '0; dc_reqtag = '0;
        ic_respack = 0; dc_respack = 0;
        bus_reqack = 0; bus_respcyc = 0; bus_resptag = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        clear_inputs();
        @(negedge clk);
        reset = 0;
    endtask

    // Table vector: inputs {ic_reqcyc, dc_reqcyc, bus_reqack, bus_respcyc,
    // resptag_matches_ic, ic_respack}; expected = ov.
    typedef struct packed {
        logic [5:0] in;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [18];

    // Reference model state (transaction level)
    bit          m_active, m_addr, m_read;
    int          m_owner, m_last, m_left;
    logic [TW-1:0] m_tag;

    initial begin
        int run;
        int owners[$];
        int runs[$];
        int dc_respack_cnt;
        int acks, busy_cnt, resp_cnt;
        logic own_rc, own_ra, e_brc, e_ack, e_rc, e_ra, rv;
        logic [DW-1:0] own_req_v, e_req;
        logic [TW-1:0] own_tag_v, e_tag;
        logic [6:0] e_vec;
        int g;

        // IC read: address ack, foreign beat, stalls, 8 matching beats, idle.
        tbl[0]  = '{6'b100000, 7'b0000000};
        tbl[1]  = '{6'b100000, 7'b1000001};
        tbl[2]  = '{6'b101000, 7'b1100001};
        tbl[3]  = '{6'b100101, 7'b0000001};
        tbl[4]  = '{6'b100111, 7'b0001011};
        tbl[5]  = '{6'b100111, 7'b0001011};
        tbl[6]  = '{6'b100110, 7'b0001001};
        tbl[7]  = '{6'b100110, 7'b0001001};
        tbl[8]  = '{6'b100110, 7'b0001001};
        tbl[9]  = '{6'b100101, 7'b0000001};
        for (int i = 10; i < 16; i++) tbl[i] = '{6'b100111, 7'b0001011};
        tbl[16] = '{6'b000000, 7'b0000000};
        tbl[17] = '{6'b000111, 7'b0000000};

        // Reset state: outputs all zero even with requests pending.
        reset = 1;
        clear_inputs();
        ic_reqcyc = 1; dc_reqcyc = 1; bus_respcyc = 1;
        #1;
        chk("reset_outputs", all_out, '0);
        @(negedge clk);
        clear_inputs();
        reset = 0;

        // Table-driven IC read with tag filter and response stall.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            ic_reqcyc   = tbl[i].in[5];
            dc_reqcyc   = tbl[i].in[4];
            bus_reqack  = tbl[i].in[3];
            bus_respcyc = tbl[i].in[2];
            bus_resptag = tbl[i].in[1] ? 13'h1001 : 13'h0777;
            ic_respack  = tbl[i].in[0];
            ic_req      = 64'h1000;
            ic_reqtag   = 13'h1001;
            dc_respack  = 1;
            #1;
            chk($sformatf("read_vec%0d", i), ov, tbl[i].exp);
            if (i == 2) chk("read_addr_beat", {bus_reqtag, bus_req}, {13'h1001, 64'h1000});
        end

        // Ties: DC first after reset, then IC, then DC again.
        do_reset();
        ic_reqcyc = 1; dc_reqcyc = 1;
        ic_reqtag = 13'h1001; dc_reqtag = 13'h0005;
        bus_reqack = 1; bus_respcyc = 1; bus_resptag = 13'h1001;
        ic_respack = 1; dc_respack = 1;
        run = 0; dc_respack_cnt = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            #1;
            if (busy) begin
                if (run == 0) owners.push_back(dc_reqack ? 1 : 0);
                run++;
                if (owners[owners.size()-1] == 1 && bus_respack) dc_respack_cnt++;
            end else begin
                if (run > 0) runs.push_back(run);
                run = 0;
            end
        end
        chk("tie_grant0_dc", owners.size() > 0 ? owners[0] : -1, 1);
        chk("tie_grant1_ic", owners.size() > 1 ? owners[1] : -1, 0);
        chk("tie_grant2_dc", owners.size() > 2 ? owners[2] : -1, 1);
        chk("tie_write_len", runs.size() > 0 ? runs[0] : 0, 2 + BEATS - 1);
        chk("tie_read_len",  runs.size() > 1 ? runs[1] : 0, 2 + BEATS - 1);
        chk("tie_write_no_respack", dc_respack_cnt, 0);

        // DC write with reqcyc dropped for two cycles mid-burst.
        do_reset();
        dc_req = 64'h2000;
        bus_reqack = 1;
        acks = 0; busy_cnt = 0; resp_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            dc_reqcyc = (c < 12) && !(c == 5 || c == 6);
            dc_reqtag = (c <= 1) ? 13'h0005 : 13'h0aaa;
            #1;
            acks     += dc_reqack ? 1 : 0;
            busy_cnt += busy ? 1 : 0;
            resp_cnt += bus_respack ? 1 : 0;
            if (c == 1) chk("wr_addr_tag", bus_reqtag, 13'h0005);
            if (c == 3) chk("wr_data_beat", {bus_reqtag, bus_req}, {13'h0005, 64'h2000});
            if (c == 5 || c == 6) chk($sformatf("wr_drop%0d", c), {bus_reqcyc, dc_reqack, busy}, 3'b001);
        end
        chk("wr_total_acks", acks, 1 + BEATS);
        chk("wr_busy_cycles", busy_cnt, 1 + BEATS + 2);
        chk("wr_no_respack", resp_cnt, 0);

        // Reset in the middle of a read burst.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ic_reqcyc = 1; ic_reqtag = 13'h1001;
            bus_reqack = 1; bus_respcyc = 1; bus_resptag = 13'h1001; ic_respack = 1;
            #1;
            if (c == 5) chk("mid_beat4_valid", {ic_respcyc, bus_respack, busy}, 3'b111);
        end
        #2;
        reset = 1;
        #1;
        chk("mid_reset_outputs", all_out, '0);
        @(negedge clk);
        reset = 0;
        ic_reqcyc = 0; dc_reqcyc = 1; dc_reqtag = 13'h0005;
        bus_respcyc = 0;
        #1;
        chk("post_reset_idle", busy, 0);
        @(negedge clk);
        #1;
        chk("post_reset_dc_grant", {busy, dc_reqack, ic_reqack, bus_reqtag}, {3'b110, 13'h0005});

        // Randomized run against the transaction-level model.
        do_reset();
        m_active = 0; m_addr = 0; m_read = 0;
        m_owner = 0; m_last = 0; m_left = 0; m_tag = '0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ic_reqcyc   = ($urandom_range(3) != 0);
            dc_reqcyc   = ($urandom_range(3) != 0);
            ic_req      = {$urandom(), $urandom()};
            dc_req      = {$urandom(), $urandom()};
            ic_reqtag   = TW'($urandom());
            dc_reqtag   = TW'($urandom());
            bus_reqack  = 1'($urandom_range(1));
            bus_respcyc = 1'($urandom_range(1));
            bus_resptag = ($urandom_range(3) != 0) ? m_tag : TW'($urandom());
            ic_respack  = 1'($urandom_range(1));
            dc_respack  = 1'($urandom_range(1));
            #1;

            own_rc    = (m_owner == 1) ? dc_reqcyc  : ic_reqcyc;
            own_ra    = (m_owner == 1) ? dc_respack : ic_respack;
            own_req_v = (m_owner == 1) ? dc_req     : ic_req;
            own_tag_v = (m_owner == 1) ? dc_reqtag  : ic_reqtag;
            e_brc = 0; e_ack = 0; e_rc = 0; e_ra = 0; e_req = '0; e_tag = '0;
            rv = bus_respcyc && (bus_resptag == m_tag);
            if (m_active) begin
                if (m_addr) begin
                    e_brc = 1; e_req = own_req_v; e_tag = own_tag_v; e_ack = bus_reqack;
                end else if (!m_read) begin
                    e_brc = own_rc; e_req = own_req_v; e_tag = m_tag; e_ack = bus_reqack && own_rc;
                end else begin
                    e_rc = rv; e_ra = rv && own_ra;
                end
            end
            e_vec = {e_brc, e_ack && m_owner == 0, e_ack && m_owner == 1,
                     e_rc && m_owner == 0, e_rc && m_owner == 1, e_ra, m_active};
            chk("rand_ctl", ov, e_vec);
            if (e_brc) chk("rand_data", {bus_reqtag, bus_req}, {e_tag, e_req});

            // Advance the model by the upcoming clock edge.
            if (!m_active) begin
                if (ic_reqcyc || dc_reqcyc) begin
                    if (ic_reqcyc && dc_reqcyc) g = (m_last == 0) ? 1 : 0;
                    else g = dc_reqcyc ? 1 : 0;
                    m_owner = g; m_last = g;
                    m_tag = (g == 1) ? dc_reqtag : ic_reqtag;
                    m_active = 1; m_addr = 1;
                end
            end else if (m_addr) begin
                if (bus_reqack) begin
                    m_addr = 0; m_read = m_tag[TW-1]; m_left = BEATS;
                end
            end else if (!m_read) begin
                if (bus_reqack && own_rc) begin
                    m_left--;
                    if (m_left == 0) m_active = 0;
                end
            end else begin
                if (rv && own_ra) begin
                    m_left--;
                    if (m_left == 0) m_active = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
